scandbl_mode_sequencer: RTL and testbench

//  Owns the applied scandoubler/speed configuration byte (vga, scanlines, freq[2:0], csync, turbo[1:0]).

---
 rtl/scandbl_mode_sequencer_pkg.sv | 33 +++
 rtl/scandbl_mode_sequencer_frame_edge_counter.sv | 101 ++++++++++
 rtl/scandbl_mode_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_scandbl_mode_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scandbl_mode_sequencer_pkg.sv
// Shared definitions for the scandoubler mode sequencer.
//   - FSM state encodings (legacy-compatible fixed values).
//   - Bit positions of the fields inside the configuration byte:
//     {turbo[1:0], csync, freq[2:0], scanlines, vga}.
//   - Counter widths and the masked-merge helper used by the request merger.
package scandbl_mode_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WAIT_VS = 3'd1;
  localparam state_t ST_BLANK   = 3'd2;
  localparam state_t ST_APPLY   = 3'd3;
  localparam state_t ST_SETTLE  = 3'd4;

  localparam int unsigned CFG_VGA      = 0;
  localparam int unsigned CFG_SCANL    = 1;
  localparam int unsigned CFG_FREQ_LO  = 2;
  localparam int unsigned CFG_FREQ_HI  = 4;
  localparam int unsigned CFG_CSYNC    = 5;
  localparam int unsigned CFG_TURBO_LO = 6;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned WD_W  = 21;

  // Replace the bits of base selected by mask with the matching bits of din.
  function automatic logic [7:0] merge_masked(input logic [7:0] base,
                                              input logic [7:0] din,
                                              input logic [7:0] mask);
    return (base & ~mask) | (din & mask);
  endfunction

endpackage

// File: rtl/scandbl_mode_sequencer_frame_edge_counter.sv
// Frame edge detector and frame counter for the mode sequencer.
// Optional feature macro: SCANDBL_SEQ_TIMEOUT_EN (vsync-loss watchdog).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   vsync_in    vertical sync, active high, synchronous to clk
//   cnt_set     load the frame counter with 1 (edge that starts a blank interval)
//   cnt_clr     clear the frame counter
//   cnt_en      count frame edges (saturating at 15)
//   wd_run      watchdog may run (sequencer is waiting for frames)
//   wd_clr      restart the watchdog (sequencer state is changing)
//   vs_edge     rising vsync edge, or a synthetic edge from the watchdog
//   cnt         current frame count
module scandbl_mode_sequencer_frame_edge_counter
  import scandbl_mode_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync_in,
  input  logic             cnt_set,
  input  logic             cnt_clr,
  input  logic             cnt_en,
  input  logic             wd_run,
  input  logic             wd_clr,
  output logic             vs_edge,
  output logic [CNT_W-1:0] cnt
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > (2 ** WD_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..2^21-1");
  end

  logic             vs_prev_q;
  logic             real_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign real_edge = vsync_in & ~vs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
    end
  end

`ifdef SCANDBL_SEQ_TIMEOUT_EN
  localparam logic [WD_W-1:0] WdLast = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_fire;

  // After TIMEOUT_CYCLES clocks without a frame edge, pretend one arrived so a
  // mode change cannot stall forever when the new mode loses vsync.
  assign wd_fire = wd_run & (wd_q == WdLast);

  always_comb begin
    wd_d = wd_q + 1'b1;
    if (!wd_run || wd_clr || real_edge || wd_fire) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign vs_edge = real_edge | wd_fire;
`else
  logic unused_wd;
  assign unused_wd = wd_run ^ wd_clr;
  assign vs_edge   = real_edge;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_set) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_en && vs_edge && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/scandbl_mode_sequencer.sv
// Scandoubler / speed configuration sequencer.
// Owns the applied configuration byte {turbo[1:0], csync, freq[2:0], scanlines, vga}.
// Update requests from the ZXUNO register, the Prism speed port and keyboard hotkeys
// are merged every cycle (reg > prism > kbd). Speed bits [7:6] are applied at once;
// video bits [5:0] are applied only at a frame boundary with the output blanked for
// BLANK_FRAMES frames before and SETTLE_FRAMES frames after the switch.
// Optional feature macro: SCANDBL_SEQ_TIMEOUT_EN (synthetic vsync after TIMEOUT_CYCLES).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reg_we, reg_din       ZXUNO register write (full byte)
//   prism_we, prism_din   Prism speed port write (turbo bits 7:6)
//   kbd_we, kbd_din,      keyboard hotkey request, only bits set in kbd_mask apply
//   kbd_mask
//   vsync_in              vertical sync, active high, synchronous to clk
//   cfg_out               applied configuration
//   pending_out           merged requested configuration
//   video_blank           force black on the scandoubler output
//   busy                  sequencer is not idle
//   cfg_changed           high for the first cycle cfg_out shows a new value
module scandbl_mode_sequencer
  import scandbl_mode_sequencer_pkg::*;
#(
  parameter logic [7:0]  RESET_CFG      = 8'h00,
  parameter int unsigned BLANK_FRAMES   = 2,
  parameter int unsigned SETTLE_FRAMES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reg_we,
  input  logic [7:0] reg_din,
  input  logic       prism_we,
  input  logic [1:0] prism_din,
  input  logic       kbd_we,
  input  logic [7:0] kbd_din,
  input  logic [7:0] kbd_mask,
  input  logic       vsync_in,
  output logic [7:0] cfg_out,
  output logic [7:0] pending_out,
  output logic       video_blank,
  output logic       busy,
  output logic       cfg_changed
);

  if (BLANK_FRAMES == 0 || BLANK_FRAMES > 15) begin : g_bad_blank
    $error("BLANK_FRAMES must be within 1..15");
  end
  if (SETTLE_FRAMES > 15) begin : g_bad_settle
    $error("SETTLE_FRAMES must be within 0..15");
  end

  localparam logic [CNT_W:0] BlankLim   = (CNT_W + 1)'(BLANK_FRAMES);
  localparam logic [CNT_W:0] SettleLim  = (CNT_W + 1)'(SETTLE_FRAMES);
  localparam bit             SkipSettle = (SETTLE_FRAMES == 0);

  state_t           state_q, state_d;
  logic [7:0]       pending_q, pending_d;
  logic [7:0]       cfg_q, cfg_d;
  logic             blank_q, blank_d;
  logic             changed_q;

  logic             vs_edge;
  logic [CNT_W-1:0] cnt;
  logic             cnt_set, cnt_clr, cnt_en;
  logic             wd_run, wd_clr;

  logic [7:0]       diff;
  logic             speed_diff, video_diff;
  logic [CNT_W:0]   cnt_inc;
  logic             blank_done, settle_done;

  // Request merge: later assignments override earlier ones, giving reg > prism > kbd.
  always_comb begin
    pending_d = pending_q;
    if (kbd_we) begin
      pending_d = merge_masked(pending_d, kbd_din, kbd_mask);
    end
    if (prism_we) begin
      pending_d[CFG_TURBO_LO +: 2] = prism_din;
    end
    if (reg_we) begin
      pending_d = reg_din;
    end
  end

  assign diff       = pending_q ^ cfg_q;
  assign speed_diff = |diff[CFG_TURBO_LO +: 2];
  assign video_diff = |diff[CFG_CSYNC:CFG_VGA];

  // The frame that arrives this cycle already counts, so compare the incremented value.
  assign cnt_inc     = {1'b0, cnt} + 1'b1;
  assign blank_done  = ({1'b0, cnt} >= BlankLim) || (vs_edge && (cnt_inc >= BlankLim));
  assign settle_done = vs_edge && (cnt_inc >= SettleLim);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    blank_d = blank_q;
    cnt_set = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (speed_diff) begin
          cfg_d[CFG_TURBO_LO +: 2] = pending_q[CFG_TURBO_LO +: 2];
        end
        if (video_diff) begin
          state_d = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (!video_diff) begin
          // Request withdrawn before anything was blanked.
          state_d = ST_IDLE;
        end else if (vs_edge) begin
          state_d = ST_BLANK;
          blank_d = 1'b1;
          cnt_set = 1'b1;
        end
      end
      ST_BLANK: begin
        if (blank_done) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        // Snapshot all eight bits, so speed requests made while busy land here too.
        cfg_d   = pending_q;
        cnt_clr = 1'b1;
        if (SkipSettle) begin
          state_d = ST_IDLE;
          blank_d = 1'b0;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_done) begin
          if (pending_q[CFG_CSYNC:CFG_VGA] != cfg_q[CFG_CSYNC:CFG_VGA]) begin
            // A newer video request arrived; chain into another blank without unblanking.
            state_d = ST_BLANK;
            cnt_set = 1'b1;
          end else begin
            state_d = ST_IDLE;
            blank_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        blank_d = 1'b0;
      end
    endcase
  end

  assign cnt_en = (state_q == ST_BLANK) || (state_q == ST_SETTLE);
  assign wd_run = (state_q == ST_WAIT_VS) || (state_q == ST_BLANK) || (state_q == ST_SETTLE);
  assign wd_clr = (state_d != state_q);

  scandbl_mode_sequencer_frame_edge_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_edge_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync_in (vsync_in),
    .cnt_set  (cnt_set),
    .cnt_clr  (cnt_clr),
    .cnt_en   (cnt_en),
    .wd_run   (wd_run),
    .wd_clr   (wd_clr),
    .vs_edge  (vs_edge),
    .cnt      (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= RESET_CFG;
      cfg_q     <= RESET_CFG;
      blank_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cfg_q     <= cfg_d;
      blank_q   <= blank_d;
      changed_q <= (cfg_d != cfg_q);
    end
  end

  assign cfg_out     = cfg_q;
  assign pending_out = pending_q;
  assign video_blank = blank_q;
  assign busy        = (state_q != ST_IDLE);
  assign cfg_changed = changed_q;

endmodule

// File: tb/tb_scandbl_mode_sequencer.sv
// Self-checking bench for scandbl_mode_sequencer: a per-cycle vector table for the
// merge / speed / abort behaviour plus hand-written frame sequences for the blanking
// protocol. A second instance (BLANK_FRAMES=1, SETTLE_FRAMES=0) covers the range ends.
module tb_scandbl_mode_sequencer;

`ifdef SCANDBL_SEQ_TIMEOUT_EN
  localparam int unsigned TbTimeout = 100;
`else
  localparam int unsigned TbTimeout = 2000000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reg_we, prism_we, kbd_we, vsync_in;
  logic [7:0] reg_din, kbd_din, kbd_mask;
  logic [1:0] prism_din;
  logic [7:0] cfg_out, pending_out, cfg_b, pending_b;
  logic       video_blank, busy, cfg_changed, blank_b, busy_b, changed_b;

  always #5 clk = ~clk;

  scandbl_mode_sequencer #(
    .RESET_CFG     (8'h00),
    .BLANK_FRAMES  (2),
    .SETTLE_FRAMES (3),
    .TIMEOUT_CYCLES(TbTimeout)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_we     (reg_we),
    .reg_din    (reg_din),
    .prism_we   (prism_we),
    .prism_din  (prism_din),
    .kbd_we     (kbd_we),
    .kbd_din    (kbd_din),
    .kbd_mask   (kbd_mask),
    .vsync_in   (vsync_in),
    .cfg_out    (cfg_out),
    .pending_out(pending_out),
    .video_blank(video_blank),
    .busy       (busy),
    .cfg_changed(cfg_changed)
  );

  scandbl_mode_sequencer #(
    .RESET_CFG     (8'h00),
    .BLANK_FRAMES  (1),
    .SETTLE_FRAMES (0),
    .TIMEOUT_CYCLES(TbTimeout)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_we     (reg_we),
    .reg_din    (reg_din),
    .prism_we   (prism_we),
    .prism_din  (prism_din),
    .kbd_we     (kbd_we),
    .kbd_din    (kbd_din),
    .kbd_mask   (kbd_mask),
    .vsync_in   (vsync_in),
    .cfg_out    (cfg_b),
    .pending_out(pending_b),
    .video_blank(blank_b),
    .busy       (busy_b),
    .cfg_changed(changed_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Event monitor, sampled on the falling edge.
  int   chg_cnt = 0;
  int   blank_rise = 0;
  int   idle_bad = 0;
  logic mon_idle = 1'b0;
  logic blank_prev = 1'b0;

  always @(negedge clk) begin
    if (cfg_changed) chg_cnt++;
    if (video_blank && !blank_prev) blank_rise++;
    if (mon_idle && (cfg_out != 8'h00 || video_blank || busy)) idle_bad++;
    blank_prev <= video_blank;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_we = 1'b0; reg_din = 8'h00; prism_we = 1'b0; prism_din = 2'b00;
    kbd_we = 1'b0; kbd_din = 8'h00; kbd_mask = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    vsync_in = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chg_cnt = 0;
    blank_rise = 0;
  endtask

  task automatic vs_pulse();
    vsync_in = 1'b1;
    step();
    step();
    vsync_in = 1'b0;
    repeat (6) step();
  endtask

  task automatic reg_write(input logic [7:0] d);
    reg_we = 1'b1; reg_din = d;
    step();
    reg_we = 1'b0;
  endtask

  typedef struct {
    logic       reg_we;
    logic [7:0] reg_din;
    logic       prism_we;
    logic [1:0] prism_din;
    logic       kbd_we;
    logic [7:0] kbd_din;
    logic [7:0] kbd_mask;
    logic [7:0] exp_cfg;
    logic [7:0] exp_pend;
    logic       exp_chg;
    logic       exp_busy;
  } vec_t;

  function automatic vec_t mk(input logic rw, input logic [7:0] rd, input logic pw,
                              input logic [1:0] pd, input logic kw, input logic [7:0] kd,
                              input logic [7:0] km, input logic [7:0] ec, input logic [7:0] ep,
                              input logic ech, input logic eb);
    vec_t v;
    v.reg_we = rw; v.reg_din = rd; v.prism_we = pw; v.prism_din = pd;
    v.kbd_we = kw; v.kbd_din = kd; v.kbd_mask = km;
    v.exp_cfg = ec; v.exp_pend = ep; v.exp_chg = ech; v.exp_busy = eb;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    // Each row drives one cycle; expectations are the outputs right after that edge.
    //            reg        prism      kbd din/mask          cfg    pend  chg busy
    vecs[0]  = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[1]  = mk(0, 8'h00, 1, 2'b10, 0, 8'h00, 8'h00, 8'h00, 8'h80, 0, 0);
    vecs[2]  = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 8'h80, 8'h80, 1, 0);
    vecs[3]  = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 8'h80, 8'h80, 0, 0);
    vecs[4]  = mk(0, 8'h00, 0, 2'b00, 1, 8'h40, 8'hC0, 8'h80, 8'h40, 0, 0);
    vecs[5]  = mk(0, 8'h00, 1, 2'b11, 1, 8'h00, 8'hC0, 8'h40, 8'hC0, 1, 0);
    vecs[6]  = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 8'hC0, 8'hC0, 1, 0);
    vecs[7]  = mk(1, 8'h05, 1, 2'b11, 1, 8'hFF, 8'hFF, 8'hC0, 8'h05, 0, 0);
    vecs[8]  = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 8'h00, 8'h05, 1, 1);
    vecs[9]  = mk(0, 8'h00, 0, 2'b00, 1, 8'h00, 8'h07, 8'h00, 8'h00, 0, 1);
    vecs[10] = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    vecs[11] = mk(0, 8'h00, 1, 2'b01, 1, 8'hC0, 8'h80, 8'h00, 8'h40, 0, 0);
    vecs[12] = mk(0, 8'h00, 0, 2'b00, 0, 8'h00, 8'h00, 8'h40, 8'h40, 1, 0);
    vecs[13] = mk(0, 8'h00, 0, 2'b00, 1, 8'h3F, 8'h00, 8'h40, 8'h40, 0, 0);

    idle_inputs();
    vsync_in = 1'b0;
    rst_n = 1'b0;
    step();
    check("reset state", {cfg_out, pending_out, cfg_changed, video_blank, busy},
          {8'h00, 8'h00, 3'b000});
    rst_n = 1'b1;
    step();

    // Ten frames with no requests: nothing may move.
    mon_idle = 1'b1;
    repeat (10) vs_pulse();
    mon_idle = 1'b0;
    check("quiet frames", idle_bad, 0);
    check("quiet end", {cfg_out, video_blank, busy}, {8'h00, 2'b00});

    for (int i = 0; i < 14; i++) begin
      reg_we = vecs[i].reg_we; reg_din = vecs[i].reg_din;
      prism_we = vecs[i].prism_we; prism_din = vecs[i].prism_din;
      kbd_we = vecs[i].kbd_we; kbd_din = vecs[i].kbd_din; kbd_mask = vecs[i].kbd_mask;
      step();
      idle_inputs();
      check($sformatf("vector %0d", i), {cfg_out, pending_out, cfg_changed, video_blank, busy},
            {vecs[i].exp_cfg, vecs[i].exp_pend, vecs[i].exp_chg, 1'b0, vecs[i].exp_busy});
    end

    // Plain video change.
    do_reset();
    reg_write(8'h01);
    step();
    check("t3 waiting", {cfg_out, video_blank, busy}, {8'h00, 2'b01});
    vs_pulse();
    check("t3 blank on vs1", {cfg_out, video_blank, busy}, {8'h00, 2'b11});
    check("b short sequence", {cfg_b, blank_b, busy_b}, {8'h01, 2'b00});
    vs_pulse();
    check("t3 apply on vs2", {cfg_out, video_blank, busy}, {8'h01, 2'b11});
    vs_pulse();
    vs_pulse();
    check("t3 settling", {cfg_out, video_blank, busy}, {8'h01, 2'b11});
    vs_pulse();
    check("t3 done", {cfg_out, video_blank, busy}, {8'h01, 2'b00});
    check("t3 events", {chg_cnt[7:0], blank_rise[7:0]}, {8'd1, 8'd1});

    // Same-cycle strobes from all three sources.
    do_reset();
    reg_we = 1'b1; reg_din = 8'h05; prism_we = 1'b1; prism_din = 2'b11;
    kbd_we = 1'b1; kbd_din = 8'hFF; kbd_mask = 8'hFF;
    step();
    idle_inputs();
    check("t4 reg wins", pending_out, 8'h05);

    // New video request during SETTLE chains into another blank interval.
    do_reset();
    reg_write(8'h01);
    step();
    vs_pulse();
    vs_pulse();
    reg_write(8'h03);
    vs_pulse();
    vs_pulse();
    vs_pulse();
    check("t5 reblank", {cfg_out, video_blank, busy}, {8'h01, 2'b11});
    vs_pulse();
    check("t5 second apply", {cfg_out, video_blank, busy}, {8'h03, 2'b11});
    vs_pulse();
    vs_pulse();
    check("t5 settling", video_blank, 1'b1);
    vs_pulse();
    check("t5 done", {cfg_out, video_blank, busy}, {8'h03, 2'b00});
    check("t5 events", {chg_cnt[7:0], blank_rise[7:0]}, {8'd2, 8'd1});

    // Speed request while busy is held until APPLY.
    do_reset();
    reg_write(8'h01);
    step();
    prism_we = 1'b1; prism_din = 2'b11;
    step();
    idle_inputs();
    step();
    step();
    check("t7 speed held", {cfg_out, pending_out, busy}, {8'h00, 8'hC1, 1'b1});
    vs_pulse();
    check("t7 speed held blank", cfg_out, 8'h00);
    vs_pulse();
    check("t7 applied", cfg_out, 8'hC1);
    repeat (3) vs_pulse();
    check("t7 done", {cfg_out, busy}, {8'hC1, 1'b0});

`ifdef SCANDBL_SEQ_TIMEOUT_EN
    // Vsync lost: the watchdog supplies the frame edges.
    begin
      int waited;
      do_reset();
      reg_write(8'h01);
      waited = 1;
      while (cfg_out != 8'h01 && waited < 300) begin
        step();
        waited++;
      end
      check("t6 applied by 300", cfg_out, 8'h01);
      while (busy && waited < 600) begin
        step();
        waited++;
      end
      check("t6 idle by 600", {busy, video_blank}, 2'b00);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
